// File: rtl/proc_sequencer_if.sv
// Run-control bus between the 3BC sequencer and its surroundings
// (start handshake, instruction word, PC control, write gates, status).
interface proc_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic [8:0]       instruction;
    logic             pc_init;
    logic             pc_en;
    logic             reg_wr_gate;
    logic             mem_wr_gate;
    logic             busy;
    logic             done;
    logic [PC_W-1:0]  init_addr;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, start_addr, instruction,
        input  pc_init, pc_en, reg_wr_gate, mem_wr_gate, busy, done, init_addr, cycle_count
    );

    modport slave (
        input  start, start_addr, instruction,
        output pc_init, pc_en, reg_wr_gate, mem_wr_gate, busy, done, init_addr, cycle_count
    );
endinterface

// File: rtl/proc_sequencer.sv
// Run-control FSM for the 3BC single-cycle processor: start/done handshake,
// PC start-address load, write gating, LDR stall insertion and cycle counting.
module proc_sequencer #(
    parameter int         PC_W    = 10,
    parameter int         CNT_W   = 16,
    parameter int         MEM_LAT = 1,
    parameter logic [3:0] LDR_OP  = 4'b1011
) (
    input logic             clk,
    input logic             rst_n,
    proc_sequencer_if.slave bus
);
    // state      | meaning
    // S_IDLE     | waiting for start after reset
    // S_INIT     | start held high; PC loads the start address
    // S_RUN      | one instruction per cycle
    // S_MEM_WAIT | LDR stall while data memory returns read data
    // S_DONE     | halt word reached; done held until next start
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_MEM_WAIT,
        S_DONE
    } state_t;

    localparam logic [8:0]        HALT_WORD = 9'h1FF;
    localparam int                WAIT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  cycle_count;
    logic [PC_W-1:0]   init_addr;
    logic              is_halt, is_ldr, cnt_inc;
    logic              pc_en, reg_wr_gate, mem_wr_gate;

    assign is_halt = (bus.instruction == HALT_WORD);
    assign is_ldr  = (bus.instruction[8:5] == LDR_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_en        = 1'b0;
        reg_wr_gate  = 1'b0;
        mem_wr_gate  = 1'b0;
        cnt_inc      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_INIT;
            end
            S_INIT: begin
                if (!bus.start) state_nxt = S_RUN;
            end
            S_RUN: begin
                cnt_inc = !is_halt;
                // start aborts the program and wins over any decode
                if (bus.start) begin
                    state_nxt = S_INIT;
                end else if (is_halt) begin
                    state_nxt = S_DONE;
                end else if (is_ldr && (MEM_LAT > 0)) begin
                    wait_cnt_nxt = WAIT_INIT;
                    state_nxt    = S_MEM_WAIT;
                end else begin
                    pc_en       = 1'b1;
                    reg_wr_gate = 1'b1;
                    mem_wr_gate = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                cnt_inc = 1'b1;
                if (bus.start) begin
                    state_nxt = S_INIT;
                end else if (wait_cnt != '0) begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end else begin
                    // final LDR cycle: write back the loaded value, never store
                    pc_en       = 1'b1;
                    reg_wr_gate = 1'b1;
                    state_nxt   = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.start) state_nxt = S_INIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            init_addr   <= '0;
        end else begin
            if (state == S_INIT) begin
                cycle_count <= '0;
                init_addr   <= bus.start_addr;
            end else if (cnt_inc && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    assign bus.pc_init     = (state == S_INIT);
    assign bus.busy        = (state == S_RUN) || (state == S_MEM_WAIT);
    assign bus.done        = (state == S_DONE);
    assign bus.pc_en       = pc_en;
    assign bus.reg_wr_gate = reg_wr_gate;
    assign bus.mem_wr_gate = mem_wr_gate;
    assign bus.init_addr   = init_addr;
    assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: two instances (MEM_LAT=2/CNT_W=16 and MEM_LAT=0/CNT_W=3)
// run the same programs from a shared ROM; a program-level model feeds per-instance scoreboards.
module tb_proc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start;
    logic [9:0] start_addr;
    logic [8:0] rom [0:1023];
    logic [9:0] pc_a, pc_b;
    logic [8:0] prog [$];
    bit sb_en = 1'b0;
    logic pd_a = 1'b0, pd_b = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_done;
        logic [2:0] gates;
        int         count;
    } exp_t;
    exp_t qa [$];
    exp_t qb [$];

    proc_sequencer_if #(.PC_W(10), .CNT_W(16)) bus_a ();
    proc_sequencer_if #(.PC_W(10), .CNT_W(3))  bus_b ();

    proc_sequencer #(.PC_W(10), .CNT_W(16), .MEM_LAT(2), .LDR_OP(4'b1011)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    proc_sequencer #(.PC_W(10), .CNT_W(3), .MEM_LAT(0), .LDR_OP(4'b1011)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    always #5 clk = ~clk;

    assign bus_a.start = start;
    assign bus_b.start = start;
    assign bus_a.start_addr = start_addr;
    assign bus_b.start_addr = start_addr;
    assign bus_a.instruction = rom[pc_a];
    assign bus_b.instruction = rom[pc_b];

    // simple PC per instance: load on pc_init, increment on pc_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_a <= '0;
            pc_b <= '0;
        end else begin
            if (bus_a.pc_init) pc_a <= bus_a.init_addr;
            else if (bus_a.pc_en) pc_a <= pc_a + 10'd1;
            if (bus_b.pc_init) pc_b <= bus_b.init_addr;
            else if (bus_b.pc_en) pc_b <= pc_b + 10'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] rand_alu();
        logic [8:0] v;
        v = 9'($urandom);
        if (v[8:5] == 4'b1011 || v == 9'h1FF) v[8:5] = 4'b0001;
        return v;
    endfunction

    function automatic logic [8:0] rand_ldr();
        logic [8:0] v;
        v = 9'($urandom);
        v[8:5] = 4'b1011;
        return v;
    endfunction

    task automatic put(input bit which, input bit is_done, input logic [2:0] g, input int cnt);
        exp_t e;
        e.is_done = is_done;
        e.gates = g;
        e.count = cnt;
        if (which) qb.push_back(e);
        else qa.push_back(e);
    endtask

    // Program-level model: every instruction is one cycle with all gates open,
    // except LDR with latency L, which is L closed cycles then a cycle with
    // PC/reg write open and store closed. Halt cycle has gates closed, uncounted.
    task automatic push_expected(input bit which);
        int lat, cmax, n;
        lat  = which ? 0 : 2;
        cmax = which ? 7 : 65535;
        n = 0;
        foreach (prog[i]) begin
            if (prog[i][8:5] == 4'b1011 && lat > 0) begin
                repeat (lat) put(which, 1'b0, 3'b000, 0);
                put(which, 1'b0, 3'b110, 0);
                n += lat + 1;
            end else begin
                put(which, 1'b0, 3'b111, 0);
                n += 1;
            end
        end
        put(which, 1'b0, 3'b000, 0);
        put(which, 1'b1, 3'b000, (n > cmax) ? cmax : n);
    endtask

    task automatic mon(input bit which, input logic busy, input logic [2:0] g,
                       input logic done_rise, input int cnt);
        exp_t e;
        int sz;
        if (busy) begin
            sz = which ? qb.size() : qa.size();
            checks++;
            if (sz == 0) begin
                errors++;
                $display("FAIL sb_gates dut%0d: busy with nothing expected, gates=%b", which, g);
            end else begin
                if (which) e = qb.pop_front();
                else e = qa.pop_front();
                if (e.is_done || g !== e.gates) begin
                    errors++;
                    $display("FAIL sb_gates dut%0d: got gates=%b busy, expected gates=%b done=%0d",
                             which, g, e.gates, e.is_done);
                end
            end
        end
        if (done_rise) begin
            sz = which ? qb.size() : qa.size();
            checks++;
            if (sz == 0) begin
                errors++;
                $display("FAIL sb_done dut%0d: done with nothing expected, count=%0d", which, cnt);
            end else begin
                if (which) e = qb.pop_front();
                else e = qa.pop_front();
                if (!e.is_done || cnt != e.count) begin
                    errors++;
                    $display("FAIL sb_done dut%0d: got done count=%0d, expected done=%0d count=%0d",
                             which, cnt, e.is_done, e.count);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            mon(1'b0, bus_a.busy, {bus_a.pc_en, bus_a.reg_wr_gate, bus_a.mem_wr_gate},
                bus_a.done && !pd_a, int'(bus_a.cycle_count));
            mon(1'b1, bus_b.busy, {bus_b.pc_en, bus_b.reg_wr_gate, bus_b.mem_wr_gate},
                bus_b.done && !pd_b, int'(bus_b.cycle_count));
        end
        pd_a = bus_a.done;
        pd_b = bus_b.done;
    end

    task automatic load_rom(input logic [9:0] addr);
        logic [9:0] ix;
        ix = addr;
        foreach (prog[i]) begin
            rom[ix] = prog[i];
            ix = ix + 10'd1;
        end
        rom[ix] = 9'h1FF;
    endtask

    task automatic run_program(input int hold, input logic [9:0] addr);
        int n;
        sb_en = 1'b0;
        qa.delete();
        qb.delete();
        load_rom(addr);
        start_addr = addr;
        start = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("pc_init_during_start", int'(bus_a.pc_init), 1);
            chk("done_clear_on_start", int'(bus_a.done), 0);
        end
        push_expected(1'b0);
        push_expected(1'b1);
        sb_en = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_after_start", int'(bus_a.busy), 1);
        chk("init_addr", int'(bus_a.init_addr), int'(addr));
        n = 0;
        while (!(bus_a.done && bus_b.done) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("run_reaches_done", int'({bus_a.done, bus_b.done}), 3);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("done_held", int'(bus_a.done), 1);
        end
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
    endtask

    initial begin
        int n;
        logic [9:0] addr;
        for (int i = 0; i < 1024; i++) rom[i] = 9'h1FF;
        start = 1'b0;
        start_addr = '0;
        rst_n = 1'b0;
        #3;
        chk("rst_pc_init", int'(bus_a.pc_init), 0);
        chk("rst_pc_en", int'(bus_a.pc_en), 0);
        chk("rst_reg_gate", int'(bus_a.reg_wr_gate), 0);
        chk("rst_mem_gate", int'(bus_a.mem_wr_gate), 0);
        chk("rst_busy", int'(bus_a.busy), 0);
        chk("rst_done", int'(bus_a.done), 0);
        chk("rst_init_addr", int'(bus_a.init_addr), 0);
        chk("rst_cycle_count", int'(bus_a.cycle_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", int'(bus_a.busy), 0);

        // four ALU ops then halt, start held three cycles
        prog.delete();
        repeat (4) prog.push_back(rand_alu());
        run_program(3, 10'h040);

        // ALU, LDR, ALU
        prog.delete();
        prog.push_back(rand_alu());
        prog.push_back(rand_ldr());
        prog.push_back(rand_alu());
        run_program(2, 10'h123);

        // ten ALU ops: 3-bit counter saturates at 7
        prog.delete();
        repeat (10) prog.push_back(rand_alu());
        run_program(2, 10'h3FA);

        // abort while instance A waits on the final stall cycle of an LDR
        sb_en = 1'b0;
        prog.delete();
        prog.push_back(rand_ldr());
        prog.push_back(rand_alu());
        prog.push_back(rand_alu());
        addr = 10'h200;
        load_rom(addr);
        start_addr = addr;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_busy", int'(bus_a.busy), 1);
        start = 1'b1;
        #1;
        chk("abort_gates_a", int'({bus_a.pc_en, bus_a.reg_wr_gate, bus_a.mem_wr_gate}), 0);
        chk("abort_gates_b", int'({bus_b.pc_en, bus_b.reg_wr_gate, bus_b.mem_wr_gate}), 0);
        @(posedge clk);
        #1;
        chk("abort_pc_init", int'(bus_a.pc_init), 1);
        chk("abort_busy", int'(bus_a.busy), 0);
        chk("abort_done", int'(bus_a.done), 0);
        run_program(2, addr);

        for (int p = 0; p < 25; p++) begin
            prog.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) prog.push_back(rand_ldr());
                else prog.push_back(rand_alu());
            end
            run_program($urandom_range(2, 4), 10'($urandom));
        end

        // asynchronous reset in the middle of a run
        sb_en = 1'b0;
        qa.delete();
        qb.delete();
        prog.delete();
        repeat (8) prog.push_back(rand_alu());
        load_rom(10'h010);
        start_addr = 10'h010;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (bus_a.cycle_count != 16'd5 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrun_count", int'(bus_a.cycle_count), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", int'(bus_a.busy), 0);
        chk("midrun_rst_pc_init", int'(bus_a.pc_init), 0);
        chk("midrun_rst_done", int'(bus_a.done), 0);
        chk("midrun_rst_count", int'(bus_a.cycle_count), 0);
        chk("midrun_rst_gates", int'({bus_a.pc_en, bus_a.reg_wr_gate, bus_a.mem_wr_gate}), 0);
        chk("midrun_rst_count_b", int'(bus_b.cycle_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", int'(bus_a.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
Run-control state machine for the 3BC single-cycle processor. Handles the Start/Done handshake with the testbench and loads the program counter with the program start address. Gates the PC advance and the register-file and data-memory write enables (ANDed downstream with Ctrl's RegWrEn/StoreInst). Inserts stall cycles for LDR when data memory has read latency, stops on the halt word, and counts executed cycles.

Parameters:
PC_W, 10, program counter / start address width
CNT_W, 16, cycle counter width
MEM_LAT, 1, extra stall cycles per LDR (0 = no stall)
LDR_OP, 4'b1011, opcode (Instruction[8:5]) of LDR

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  testbench start; high = hold in init, falling edge = run
StartAddr  input  PC_W  program start address, sampled while in INIT
Instruction  input  9  current instruction from instruction ROM
PCInit  output  1  PC loads StartAddr this cycle
PCEn  output  1  PC advances (next/branch target) this cycle
RegWrGate  output  1  permits reg_file write this cycle
MemWrGate  output  1  permits data-memory write this cycle
Busy  output  1  in RUN or MEM_WAIT
Done  output  1  program finished; held until next Start
InitAddr  output  PC_W  registered copy of StartAddr driven to PC
CycleCount  output  CNT_W  cycles spent in RUN+MEM_WAIT for the last/current program

Behaviour:
- States: IDLE, INIT, RUN, MEM_WAIT, DONE. State register async-cleared by Reset_n=0 at any time, including mid-program.
- Reset values: state=IDLE; all 1-bit outputs 0; InitAddr=0; CycleCount=0; wait counter=0.
- PCInit, Busy, Done decoded from registered state only (no input-to-output path). PCEn/RegWrGate/MemWrGate in RUN depend combinationally on Instruction.
- IDLE: all gates 0. Start=1 -> INIT.
- INIT: PCInit=1; InitAddr<=StartAddr each cycle; CycleCount<=0. Remain while Start=1; Start=0 -> RUN.
- RUN, halt word (Instruction==9'h1FF): PCEn=0, gates=0, -> DONE. The halt cycle is not counted.
- RUN, Instruction[8:5]==LDR_OP and MEM_LAT>0: PCEn=0, RegWrGate=0, MemWrGate=0; wait counter<=MEM_LAT-1; -> MEM_WAIT.
- RUN, any other instruction (including LDR when MEM_LAT=0): PCEn=1, RegWrGate=1, MemWrGate=1; stay in RUN.
- MEM_WAIT: gates 0 while wait counter!=0, counter decrements. At counter==0: PCEn=1, RegWrGate=1, MemWrGate=0, -> RUN. An LDR therefore occupies exactly MEM_LAT+1 cycles.
- CycleCount increments by 1 every cycle in RUN (non-halt) or MEM_WAIT. It saturates at all-ones and does not wrap. It holds its value in DONE and IDLE.
- Start=1 in RUN or MEM_WAIT: abort. Next state is INIT and no gate asserts that cycle. Start has priority over halt and LDR decode.
- DONE: Done=1, all gates 0. Start=1 -> INIT; Done falls on the same edge.
- Start=1 and halt word present on the same cycle in RUN: go to INIT; Done is not asserted.
- Reset_n deassertion is taken synchronously by the design's own flops (no internal synchroniser). The first active edge after release evaluates IDLE.

Test Plan:
- Reset_n=0 mid-RUN (CycleCount=5) -> next sample: state IDLE, PCInit=Busy=Done=0, CycleCount=0, no clock edge needed.
- Start high 3 cycles with StartAddr=10'h040, then low -> PCInit=1 for 3 cycles, InitAddr=0x040, Busy=1 on first post-Start cycle.
- Program of 4 ALU ops then 9'h1FF -> PCEn/RegWrGate high 4 cycles, Done=1 the cycle after halt, CycleCount=4; Done stays 1 until Start.
- MEM_LAT=2, one LDR (opcode 1011) among 2 ALU ops -> LDR gates low 2 cycles, then PCEn=RegWrGate=1, MemWrGate=0; CycleCount=5 at halt. Repeat with MEM_LAT=0 -> LDR takes 1 cycle, CycleCount=3.
- Start=1 asserted during MEM_WAIT -> next cycle INIT, PCInit=1, no write gate pulse; Start low restarts with CycleCount cleared.
- CNT_W=3, 10-instruction loop before halt -> CycleCount saturates at 7, no wrap.
